aes256_key_expand: RTL and testbench



---
 rtl/aes256_key_expand.sv | 137 +++++++++++++
 tb/tb_aes256_key_expand.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: streams round keys RK0..RK14 over valid/ready,
// computing one 128-bit round key per accepted beat from a two-key window.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = ginv(a);
    c = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

module aes256_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key,
  input  logic         start,
  output logic         ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] rk_data,
  output logic         done
);

  typedef enum logic {IDLE, GEN} state_t;

  state_t       state;
  logic [127:0] prev;
  logic [127:0] cur;
  logic [7:0]   rcon;
  logic [31:0]  last_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  t;
  logic [31:0]  n0, n1, n2, n3;
  logic         even_next;
  logic         fire;

  assign ready = (state == IDLE);
  assign fire  = rk_valid && rk_ready;

  // The key being generated is RK(index+1); it is even when the current index is odd
  assign even_next = rk_index[0];
  assign last_word = cur[31:0];
  assign sub_in    = even_next ? {last_word[23:0], last_word[31:24]} : last_word;

  sbox u_sbox0 (.a(sub_in[31:24]), .c(sub_out[31:24]));
  sbox u_sbox1 (.a(sub_in[23:16]), .c(sub_out[23:16]));
  sbox u_sbox2 (.a(sub_in[15:8]),  .c(sub_out[15:8]));
  sbox u_sbox3 (.a(sub_in[7:0]),   .c(sub_out[7:0]));

  assign t  = even_next ? (sub_out ^ {rcon, 24'h000000}) : sub_out;
  assign n0 = prev[127:96] ^ t;
  assign n1 = prev[95:64]  ^ n0;
  assign n2 = prev[63:32]  ^ n1;
  assign n3 = prev[31:0]   ^ n2;

  // prev/cur hold the window {RK(k-1), RK(k)} once k >= 1; RK0/RK1 come straight from the key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= '0;
      cur      <= '0;
      rcon     <= 8'h01;
      rk_index <= 4'd0;
      rk_data  <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            prev     <= key[255:128];
            cur      <= key[127:0];
            rk_data  <= key[255:128];
            rk_index <= 4'd0;
            rcon     <= 8'h01;
            rk_valid <= 1'b1;
            state    <= GEN;
          end
        end
        GEN: begin
          if (fire) begin
            if (rk_index == 4'd14) begin
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else if (rk_index == 4'd0) begin
              rk_data  <= cur;
              rk_index <= 4'd1;
            end else begin
              rk_data  <= {n0, n1, n2, n3};
              prev     <= cur;
              cur      <= {n0, n1, n2, n3};
              rk_index <= rk_index + 4'd1;
              if (even_next) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Self-checking bench for aes256_key_expand: compares every streamed round key
// against a word-array key-expansion model, under random backpressure and resets.

module tb_aes256_key_expand;

  logic         clk;
  logic         rst;
  logic [255:0] key;
  logic         start;
  logic         ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_index;
  logic [127:0] rk_data;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbt [256];
  logic [127:0] seen [15];

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes256_key_expand dut (
    .clk(clk), .rst(rst), .key(key), .start(start), .ready(ready),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_index(rk_index),
    .rk_data(rk_data), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // S-box table built by walking the multiplicative group with generator 3
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbt[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  task automatic expandModel(input logic [255:0] k, output logic [127:0] ek [15]);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        rc  = 8'h01 << (i/8 - 1);
        tmp = subWord({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
      end else if (i % 8 == 4) begin
        tmp = subWord(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Runs one expansion; optionally pokes start mid-run, aborts with reset, or chains another start
  task automatic applyStimulus(input logic [255:0] k, input int ready_pct, input int start_at,
                               input logic [255:0] bad_key, input bit pre_started,
                               input bit chain, input logic [255:0] next_key, input int abort_at);
    logic [127:0] ek [15];
    int idx;
    int cycles;
    int g;
    bit r;
    expandModel(k, ek);
    if (!pre_started) begin
      g = 0;
      while (!ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      checkOutput("ready_wait", {127'd0, ready}, 128'd1);
      key   = k;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    idx    = 0;
    cycles = 0;
    while (idx <= 14 && cycles < 400) begin
      checkOutput("valid", {127'd0, rk_valid}, 128'd1);
      checkOutput("index", {124'd0, rk_index}, 128'(idx));
      checkOutput($sformatf("data_rk%0d", idx), rk_data, ek[idx]);
      checkOutput("ready_low", {127'd0, ready}, 128'd0);
      checkOutput("done_low", {127'd0, done}, 128'd0);
      seen[idx] = rk_data;
      if (idx == abort_at) begin
        rk_ready = 1'b0;
        start    = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_valid", {127'd0, rk_valid}, 128'd0);
        checkOutput("rst_ready", {127'd0, ready}, 128'd1);
        checkOutput("rst_index", {124'd0, rk_index}, 128'd0);
        checkOutput("rst_data", rk_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (idx == start_at) begin
        start = 1'b1;
        key   = bad_key;
      end else begin
        start = 1'b0;
      end
      r = ($urandom_range(99) < ready_pct);
      rk_ready = r;
      @(negedge clk);
      cycles++;
      if (r) idx++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    checkOutput("timeout", 128'(idx), 128'd15);
    if (ready_pct >= 100) checkOutput("latency", 128'(cycles), 128'd15);
    checkOutput("done_pulse", {127'd0, done}, 128'd1);
    checkOutput("end_valid", {127'd0, rk_valid}, 128'd0);
    checkOutput("end_ready", {127'd0, ready}, 128'd1);
    if (chain) begin
      key   = next_key;
      start = 1'b1;
      return;
    end
    @(negedge clk);
    checkOutput("done_clear", {127'd0, done}, 128'd0);
  endtask

  initial begin
    rst      = 1'b1;
    key      = '0;
    start    = 1'b0;
    rk_ready = 1'b0;
    buildSbox();
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", {127'd0, rk_valid}, 128'd0);
    checkOutput("reset_ready", {127'd0, ready}, 128'd1);
    checkOutput("reset_done", {127'd0, done}, 128'd0);
    checkOutput("reset_index", {124'd0, rk_index}, 128'd0);
    checkOutput("reset_data", rk_data, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] FIPS-197 C.3 key, no backpressure");
    applyStimulus(KEY_C3, 100, -1, '0, 1'b0, 1'b0, '0, -1);
    checkOutput("c3_rk0", seen[0], 128'h000102030405060708090a0b0c0d0e0f);
    checkOutput("c3_rk1", seen[1], 128'h101112131415161718191a1b1c1d1e1f);
    checkOutput("c3_rk2", seen[2], 128'ha573c29fa176c498a97fce93a572c09c);
    checkOutput("c3_rk14", seen[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    $display("[TB] FIPS-197 A.3 key");
    applyStimulus(KEY_A3, 100, -1, '0, 1'b0, 1'b0, '0, -1);
    checkOutput("a3_rk2", seen[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    checkOutput("a3_rk14", seen[14], 128'hfe4890d1e6188d0b046df344706c631e);

    $display("[TB] random backpressure");
    applyStimulus(KEY_C3, 50, -1, '0, 1'b0, 1'b0, '0, -1);

    $display("[TB] start pulsed mid-sequence");
    applyStimulus(KEY_C3, 70, 5, KEY_A3, 1'b0, 1'b0, '0, -1);

    $display("[TB] async reset at RK7 then restart");
    applyStimulus(KEY_C3, 100, -1, '0, 1'b0, 1'b0, '0, 7);
    applyStimulus(KEY_A3, 100, -1, '0, 1'b0, 1'b0, '0, -1);
    checkOutput("restart_rk14", seen[14], 128'hfe4890d1e6188d0b046df344706c631e);

    $display("[TB] back-to-back expansions");
    applyStimulus(KEY_C3, 100, -1, '0, 1'b0, 1'b1, KEY_A3, -1);
    applyStimulus(KEY_A3, 100, -1, '0, 1'b1, 1'b0, '0, -1);

    $display("[TB] random keys with backpressure");
    for (int n = 0; n < 4; n++) begin
      applyStimulus({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    60, -1, '0, 1'b0, 1'b0, '0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
